// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, widths and requant helper for the FC layer engine
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fc_state_t;

  localparam int LANES  = 128;
  localparam int BYTE_W = 8;
  localparam int MA_W   = 15;
  localparam int ROM_AW = 11;
  localparam int VEC_W  = LANES * BYTE_W;

  // Clamp an already-shifted value to one output byte; relu selects [0,127] vs [-128,127]
  function automatic logic [BYTE_W-1:0] sat_requant(input logic signed [31:0] v,
                                                    input logic relu);
    logic [BYTE_W-1:0] r;
    if (v > 32'sd127)
      r = 8'h7f;
    else if (relu && (v < 32'sd0))
      r = 8'h00;
    else if (v < -32'sd128)
      r = 8'h80;
    else
      r = v[BYTE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fc_layer_engine_requant.sv
// rtl/fc_layer_engine_requant.sv - arithmetic shift plus ReLU/signed saturation to one byte
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = 3,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [BYTE_W-1:0] q
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [31:0]      wide;

  // Shift keeps the sign, then widen so the shared clamp sees the true value
  always_comb begin
    shifted = acc >>> SHIFT;
    wide    = {{(32-ACC_W){shifted[ACC_W-1]}}, shifted};
    q       = sat_requant(wide, RELU != 0);
  end

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - fully-connected layer walker: fetch, MAC, requant, done handshake
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int IN_CHUNKS   = 8,
  parameter int OUT_NEURONS = 128,
  parameter int ROM_BASE    = 0,
  parameter int ACC_W       = 20,
  parameter int SHIFT       = 3,
  parameter int RELU        = 1
) (
  input  logic                       clk,
  input  logic                       iRst_n,
  input  logic                       ena,
  input  logic [VEC_W-1:0]           data_from_rom,
  input  logic [VEC_W-1:0]           data_from_ram,
  input  logic [MA_W-1:0]            data_from_MultAdder,
  input  logic                       overflow_from_MultAdder,
  output logic [ROM_AW-1:0]          addr_to_rom,
  output logic [2:0]                 addr_to_ram,
  output logic [VEC_W-1:0]           opr1_to_MultAdder,
  output logic [VEC_W-1:0]           opr2_to_MultAdder,
  output logic [OUT_NEURONS*8-1:0]   data_to_ram,
  output logic                       overflow,
  output logic                       done
);

  localparam int N_W = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;
  localparam int C_W = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam logic [N_W-1:0]    N_LAST    = N_W'(OUT_NEURONS - 1);
  localparam logic [C_W-1:0]    C_LAST    = C_W'(IN_CHUNKS - 1);
  localparam logic [ROM_AW-1:0] ADDR_BASE = ROM_AW'(ROM_BASE);

  fc_state_t               state, state_nxt;
  logic [N_W-1:0]          n;
  logic [C_W-1:0]          c;
  logic signed [ACC_W-1:0] acc, ma_ext, acc_sum;
  logic                    add_ovf, last_chunk, last_neuron;
  logic [BYTE_W-1:0]       q;

  assign ma_ext      = {{(ACC_W-MA_W){data_from_MultAdder[MA_W-1]}}, data_from_MultAdder};
  assign acc_sum     = acc + ma_ext;
  assign add_ovf     = (acc[ACC_W-1] == ma_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
  assign last_chunk  = (c == C_LAST);
  assign last_neuron = (n == N_LAST);
  assign addr_to_ram = 3'(c);

  fc_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(RELU)) u_requant (
    .acc (acc),
    .q   (q)
  );

  // State register
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; ena low freezes everything except the terminal state
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   state_nxt = MAC;
        MAC:     state_nxt = last_chunk ? WRITE : FETCH;
        WRITE:   state_nxt = last_neuron ? DONE : FETCH;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: operands only reach the MultAdder during MAC
  always_comb begin
    done              = (state == DONE);
    opr1_to_MultAdder = (state == MAC) ? data_from_rom : '0;
    opr2_to_MultAdder = (state == MAC) ? data_from_ram : '0;
  end

  // Counters, accumulator, linear ROM address and output bytes
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      n           <= '0;
      c           <= '0;
      acc         <= '0;
      addr_to_rom <= ADDR_BASE;
      data_to_ram <= '0;
      overflow    <= 1'b0;
    end else if (ena) begin
      case (state)
        MAC: begin
          acc <= acc_sum;
          if (overflow_from_MultAdder || add_ovf) overflow <= 1'b1;
          if (!last_chunk) c <= c + 1'b1;
          // Address walks neuron-major, so one increment per MAC tracks n*IN_CHUNKS+c;
          // the final MAC leaves it on the last word instead of running past it
          if (!(last_chunk && last_neuron)) addr_to_rom <= addr_to_rom + 1'b1;
        end
        WRITE: begin
          data_to_ram[n*BYTE_W +: BYTE_W] <= q;
          acc <= '0;
          c   <= '0;
          if (!last_neuron) n <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
